// File: rtl/sprite_overlay_compositor_pkg.sv
// Shared sprite slot type, coordinate widths and the strict-bound distance test.
// sprite_t fields are sized to the default widths; narrower instances zero-extend into them.
package sprite_pkg;

  localparam int SPR_X_W      = 10;
  localparam int SPR_Y_W      = 9;
  localparam int SPR_COLOR_W  = 24;
  localparam int CRD_W        = (SPR_X_W > SPR_Y_W) ? SPR_X_W : SPR_Y_W;
  localparam int CMP_W        = CRD_W + 2;
  localparam int DEFAULT_HALF = 20;

  typedef struct packed {
    logic                   en;
    logic                   blink;
    logic [SPR_X_W-1:0]     x;
    logic [SPR_Y_W-1:0]     y;
    logic [SPR_COLOR_W-1:0] color;
  } sprite_t;

  // Signed difference two bits wider than the coordinates, so edges never wrap.
  function automatic logic abs_diff_lt(input logic [CRD_W-1:0] a,
                                       input logic [CRD_W-1:0] b,
                                       input logic [CRD_W-1:0] half);
    logic signed [CMP_W-1:0] d;
    d = $signed({2'b00, a}) - $signed({2'b00, b});
    if (d < 0) d = -d;
    return d < $signed({2'b00, half});
  endfunction

endpackage

// File: rtl/sprite_overlay_compositor_if.sv
// Sprite slot update port (valid/ready); game/touch logic is the master.
interface sprite_overlay_compositor_if
  import sprite_pkg::*;
#(
  parameter int N_SPRITES = 4,
  parameter int X_W       = SPR_X_W,
  parameter int Y_W       = SPR_Y_W,
  parameter int COLOR_W   = SPR_COLOR_W
);
  localparam int IDX_W = (N_SPRITES > 1) ? $clog2(N_SPRITES) : 1;

  logic               iUpdValid;
  logic               oUpdReady;
  logic [IDX_W-1:0]   iUpdIdx;
  logic               iUpdEn;
  logic [X_W-1:0]     iUpdX;
  logic [Y_W-1:0]     iUpdY;
  logic [COLOR_W-1:0] iUpdColor;
  logic               iUpdBlink;

  modport master (output iUpdValid, iUpdIdx, iUpdEn, iUpdX, iUpdY, iUpdColor, iUpdBlink,
                  input  oUpdReady);
  modport slave  (input  iUpdValid, iUpdIdx, iUpdEn, iUpdX, iUpdY, iUpdColor, iUpdBlink,
                  output oUpdReady);
endinterface

// File: rtl/sprite_overlay_compositor_hit_cmp.sv
// Combinational per-slot hit test: enabled, not blanked by blink, and inside the square.
module sprite_hit_cmp
  import sprite_pkg::*;
#(
  parameter int X_W  = SPR_X_W,
  parameter int Y_W  = SPR_Y_W,
  parameter int HALF = DEFAULT_HALF
) (
  input  sprite_t        spr,
  input  logic           blink_off,
  input  logic [X_W-1:0] px,
  input  logic [Y_W-1:0] py,
  output logic           hit
);

  always_comb begin
    hit = spr.en & ~(spr.blink & blink_off)
        & abs_diff_lt(CRD_W'(spr.x), CRD_W'(px), CRD_W'(HALF))
        & abs_diff_lt(CRD_W'(spr.y), CRD_W'(py), CRD_W'(HALF));
  end

endmodule

// File: rtl/sprite_overlay_compositor.sv
// Sprite overlay compositor: shadow/active slot banks, frame-start commit, 2-stage pixel pipe.
// Optional blink support via SPRITE_BLINK_EN (8-bit frame counter, bit 4 blanks blink slots).
module sprite_overlay_compositor
  import sprite_pkg::*;
#(
  parameter int N_SPRITES = 4,
  parameter int X_W       = SPR_X_W,
  parameter int Y_W       = SPR_Y_W,
  parameter int HALF      = DEFAULT_HALF,
  parameter int COLOR_W   = SPR_COLOR_W
) (
  input  logic                         iCLK,
  input  logic                         iRST,
  input  logic                         iNewFrame,
  input  logic [COLOR_W-1:0]           iBgColor,
  sprite_overlay_compositor_if.slave   upd,
  input  logic                         iPixValid,
  input  logic [X_W-1:0]               iX,
  input  logic [Y_W-1:0]               iY,
  output logic [COLOR_W-1:0]           oColor,
  output logic                         oColorValid
);

  localparam int IDX_W = (N_SPRITES > 1) ? $clog2(N_SPRITES) : 1;

  sprite_t              shadow [N_SPRITES];
  sprite_t              active [N_SPRITES];
  sprite_t              upd_word;
  logic                 blink_off;
  logic [N_SPRITES-1:0] hit;
  logic [N_SPRITES-1:0] hit_s1;
  logic [COLOR_W-1:0]   col_s1 [N_SPRITES];
  logic [COLOR_W-1:0]   bg_s1;
  logic                 vld_s1;
  logic [COLOR_W-1:0]   sel_color;
  logic                 sel_found;

  assign upd.oUpdReady = ~iRST & ~iNewFrame;

  always_comb begin
    upd_word       = '0;
    upd_word.en    = upd.iUpdEn;
    upd_word.blink = upd.iUpdBlink;
    upd_word.x     = SPR_X_W'(upd.iUpdX);
    upd_word.y     = SPR_Y_W'(upd.iUpdY);
    upd_word.color = SPR_COLOR_W'(upd.iUpdColor);
  end

  // Commit has priority and ready is low then, so a write never races the copy.
  // Out-of-range indices match no slot and are silently dropped.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      for (int unsigned i = 0; i < N_SPRITES; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else if (iNewFrame) begin
      for (int unsigned i = 0; i < N_SPRITES; i++) active[i] <= shadow[i];
    end else if (upd.iUpdValid) begin
      for (int unsigned i = 0; i < N_SPRITES; i++)
        if (upd.iUpdIdx == IDX_W'(i)) shadow[i] <= upd_word;
    end
  end

`ifdef SPRITE_BLINK_EN
  logic [7:0] frame_cnt;

  always_ff @(posedge iCLK) begin
    if (iRST)           frame_cnt <= '0;
    else if (iNewFrame) frame_cnt <= frame_cnt + 8'd1;
  end

  assign blink_off = frame_cnt[4];
`else
  assign blink_off = 1'b0;
`endif

  for (genvar g = 0; g < N_SPRITES; g++) begin : g_cmp
    sprite_hit_cmp #(
      .X_W  (X_W),
      .Y_W  (Y_W),
      .HALF (HALF)
    ) u_cmp (
      .spr       (active[g]),
      .blink_off (blink_off),
      .px        (iX),
      .py        (iY),
      .hit       (hit[g])
    );
  end

  // Slot colours are captured with the hits so a commit in flight only affects later pixels.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      hit_s1 <= '0;
      bg_s1  <= '0;
      vld_s1 <= 1'b0;
      for (int unsigned i = 0; i < N_SPRITES; i++) col_s1[i] <= '0;
    end else begin
      hit_s1 <= hit;
      bg_s1  <= iBgColor;
      vld_s1 <= iPixValid;
      for (int unsigned i = 0; i < N_SPRITES; i++) col_s1[i] <= active[i].color[COLOR_W-1:0];
    end
  end

  always_comb begin
    sel_color = bg_s1;
    sel_found = 1'b0;
    for (int unsigned i = 0; i < N_SPRITES; i++) begin
      if (hit_s1[i] && !sel_found) begin
        sel_color = col_s1[i];
        sel_found = 1'b1;
      end
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      oColor      <= '0;
      oColorValid <= 1'b0;
    end else begin
      oColor      <= sel_color;
      oColorValid <= vld_s1;
    end
  end

endmodule

// File: tb/tb_sprite_overlay_compositor.sv
// Self-checking bench: directed scenarios plus a randomized stream against a slot-list model.
module tb_sprite_overlay_compositor;

  localparam int N  = 4;
  localparam int XW = 10;
  localparam int YW = 9;
  localparam int CW = 24;
  localparam int H  = 20;
  localparam logic [23:0] BG    = 24'h33FF66;
  localparam logic [23:0] RED   = 24'hFF0000;
  localparam logic [23:0] BLUE  = 24'h0000FF;
  localparam logic [23:0] GREEN = 24'h00FF00;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, nf, pv;
  logic [CW-1:0] bg;
  logic [XW-1:0] px;
  logic [YW-1:0] py;
  logic [CW-1:0] color;
  logic          cvalid;

  sprite_overlay_compositor_if #(.N_SPRITES(N), .X_W(XW), .Y_W(YW), .COLOR_W(CW)) upd ();

  sprite_overlay_compositor #(
    .N_SPRITES (N),
    .X_W       (XW),
    .Y_W       (YW),
    .HALF      (H),
    .COLOR_W   (CW)
  ) dut (
    .iCLK        (clk),
    .iRST        (rst),
    .iNewFrame   (nf),
    .iBgColor    (bg),
    .upd         (upd),
    .iPixValid   (pv),
    .iX          (px),
    .iY          (py),
    .oColor      (color),
    .oColorValid (cvalid)
  );

  typedef struct {
    bit          en;
    bit          blink;
    int          x;
    int          y;
    logic [23:0] c;
  } mspr_t;

  mspr_t       sh [N];
  mspr_t       ac [N];
  int          frames;
  bit          prev_v;
  logic [23:0] prev_c;
  bit          exp_v;
  logic [23:0] exp_c;
  bit          exp_ready;
  logic        seen_ready;
  int          checks = 0;
  int          failures = 0;

  function automatic int adist(int a, int b);
    return (a > b) ? a - b : b - a;
  endfunction

  // Lowest-index visible sprite whose square strictly contains the pixel, else background.
  function automatic logic [23:0] model_color(int x, int y, logic [23:0] b);
    for (int i = 0; i < N; i++) begin
      bit vis = ac[i].en;
`ifdef SPRITE_BLINK_EN
      if (ac[i].blink && ((frames / 16) % 2 == 1)) vis = 1'b0;
`endif
      if (vis && adist(x, ac[i].x) < H && adist(y, ac[i].y) < H) return ac[i].c;
    end
    return b;
  endfunction

  // One clock: sample ready mid-cycle, advance model on the edge, expose expected outputs.
  task automatic tick();
    bit          cur_v, fire;
    logic [23:0] cur_c;
    int          idx;
    #1;
    seen_ready = upd.oUpdReady;
    exp_ready  = !rst && !nf;
    cur_v      = pv && !rst;
    cur_c      = model_color(int'(px), int'(py), bg);
    fire       = upd.iUpdValid && exp_ready;
    idx        = int'(upd.iUpdIdx);
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        sh[i] = '{default: 0};
        ac[i] = '{default: 0};
      end
      frames = 0;
    end else if (nf) begin
      ac     = sh;
      frames = (frames + 1) % 256;
    end else if (fire && idx < N) begin
      sh[idx] = '{en: upd.iUpdEn, blink: upd.iUpdBlink, x: int'(upd.iUpdX),
                  y: int'(upd.iUpdY), c: upd.iUpdColor};
    end
    exp_v  = prev_v && !rst;
    exp_c  = prev_c;
    prev_v = cur_v;
    prev_c = cur_c;
    #1;
  endtask

  task automatic set_idle();
    rst = 1'b0; nf = 1'b0; pv = 1'b0;
    upd.iUpdValid = 1'b0;
  endtask

  task automatic set_upd(int idx, bit en, int x, int y, logic [23:0] c, bit b);
    upd.iUpdIdx = 2'(idx); upd.iUpdEn = en; upd.iUpdX = 10'(x);
    upd.iUpdY = 9'(y); upd.iUpdColor = c; upd.iUpdBlink = b;
  endtask

  task automatic write_slot(int idx, bit en, int x, int y, logic [23:0] c, bit b);
    set_upd(idx, en, x, y, c, b);
    upd.iUpdValid = 1'b1;
    tick();
    upd.iUpdValid = 1'b0;
  endtask

  task automatic commit();
    nf = 1'b1; tick(); nf = 1'b0;
  endtask

  task automatic probe(int x, int y);
    pv = 1'b1; px = 10'(x); py = 9'(y);
    tick();
    pv = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    checks++;
    if (seen_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b want=0", seen_ready); end
    tick();
    checks++;
    if (cvalid !== 1'b0 || color !== '0)
      begin failures++; $display("FAIL reset_out got=%b/%h want=0/000000", cvalid, color); end
    rst = 1'b0;
    tick();
    checks++;
    if (seen_ready !== 1'b1) begin failures++; $display("FAIL ready_after_reset got=%b want=1", seen_ready); end
  endtask

  task automatic test_background();
    probe(100, 100);
    checks++;
    if (cvalid !== 1'b1 || color !== BG)
      begin failures++; $display("FAIL background got=%b/%h want=1/%h", cvalid, color, BG); end
  endtask

  task automatic test_single();
    logic [23:0] want [4] = '{RED, BG, RED, BG};
    int          xs   [4] = '{181, 180, 219, 220};
    int          ys   [4] = '{200, 200, 219, 200};
    write_slot(0, 1, 200, 200, RED, 0);
    commit();
    for (int i = 0; i < 4; i++) begin
      probe(xs[i], ys[i]);
      checks++;
      if (cvalid !== 1'b1 || color !== want[i])
        begin failures++; $display("FAIL single(%0d,%0d) got=%h want=%h", xs[i], ys[i], color, want[i]); end
    end
  endtask

  task automatic test_overlap();
    write_slot(2, 1, 210, 200, BLUE, 0);
    commit();
    probe(215, 200);
    checks++;
    if (color !== RED) begin failures++; $display("FAIL overlap_prio got=%h want=%h", color, RED); end
    probe(225, 200);
    checks++;
    if (color !== BLUE) begin failures++; $display("FAIL overlap_slot2 got=%h want=%h", color, BLUE); end
  endtask

  task automatic test_edge();
    write_slot(1, 1, 5, 5, GREEN, 0);
    commit();
    probe(0, 0);
    checks++;
    if (color !== GREEN) begin failures++; $display("FAIL edge_origin got=%h want=%h", color, GREEN); end
    probe(1020, 500);
    checks++;
    if (color !== BG) begin failures++; $display("FAIL edge_nowrap got=%h want=%h", color, BG); end
  endtask

  task automatic test_commit_stall();
    write_slot(0, 1, 300, 200, RED, 0);
    probe(200, 200);
    checks++;
    if (color !== RED) begin failures++; $display("FAIL shadow_leak got=%h want=%h", color, RED); end
    set_upd(3, 1, 600, 300, 24'h123456, 0);
    upd.iUpdValid = 1'b1; nf = 1'b1;
    tick();
    checks++;
    if (seen_ready !== 1'b0) begin failures++; $display("FAIL stall_ready got=%b want=0", seen_ready); end
    nf = 1'b0;
    tick();
    checks++;
    if (seen_ready !== 1'b1) begin failures++; $display("FAIL held_write_ready got=%b want=1", seen_ready); end
    upd.iUpdValid = 1'b0;
    probe(300, 200);
    checks++;
    if (color !== RED) begin failures++; $display("FAIL moved_sprite got=%h want=%h", color, RED); end
    probe(200, 200);
    checks++;
    if (color !== BLUE) begin failures++; $display("FAIL old_position got=%h want=%h", color, BLUE); end
    probe(600, 300);
    checks++;
    if (color !== BG) begin failures++; $display("FAIL stalled_not_yet got=%h want=%h", color, BG); end
    commit();
    probe(600, 300);
    checks++;
    if (color !== 24'h123456) begin failures++; $display("FAIL stalled_committed got=%h want=123456", color); end
  endtask

  task automatic test_back_to_back();
    logic [23:0] cs [3] = '{24'hA1A1A1, 24'hB2B2B2, 24'hC3C3C3};
    upd.iUpdValid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_upd(3, 1, 800, 100, cs[i], 0);
      tick();
      checks++;
      if (seen_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready%0d got=%b want=1", i, seen_ready); end
    end
    upd.iUpdValid = 1'b0;
    commit();
    probe(800, 100);
    checks++;
    if (color !== cs[2]) begin failures++; $display("FAIL last_write_wins got=%h want=%h", color, cs[2]); end
  endtask

  task automatic test_reset_midstream();
    pv = 1'b1; px = 10'd300; py = 9'd200;
    tick(); tick();
    rst = 1'b1;
    tick();
    checks++;
    if (cvalid !== 1'b0 || color !== '0)
      begin failures++; $display("FAIL midreset_out got=%b/%h want=0/000000", cvalid, color); end
    rst = 1'b0;
    tick();
    checks++;
    if (cvalid !== 1'b0) begin failures++; $display("FAIL midreset_flush got=%b want=0", cvalid); end
    pv = 1'b0;
    tick();
    checks++;
    if (cvalid !== 1'b1 || color !== BG)
      begin failures++; $display("FAIL slots_cleared got=%b/%h want=1/%h", cvalid, color, BG); end
  endtask

  task automatic test_blink();
    logic [23:0] want;
    write_slot(0, 1, 700, 400, RED, 1);
    commit();
    for (int f = 0; f < 33; f++) begin
      probe(700, 400);
`ifdef SPRITE_BLINK_EN
      want = ((frames / 16) % 2 == 0) ? RED : BG;
`else
      want = RED;
`endif
      checks++;
      if (cvalid !== 1'b1 || color !== want)
        begin failures++; $display("FAIL blink_frame%0d got=%h want=%h", frames, color, want); end
      commit();
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 3000; n++) begin
      int j;
      rst = ($urandom_range(0, 299) == 0);
      nf  = ($urandom_range(0, 24) == 0);
      upd.iUpdValid = $urandom_range(0, 1);
      set_upd($urandom_range(0, N - 1), $urandom_range(0, 3) != 0, $urandom_range(0, 1023),
              $urandom_range(0, 511), 24'($urandom), $urandom_range(0, 1));
      bg = 24'($urandom);
      pv = ($urandom_range(0, 3) != 0);
      j  = $urandom_range(0, N - 1);
      if ($urandom_range(0, 4) == 0) begin
        px = 10'($urandom_range(0, 1023));
        py = 9'($urandom_range(0, 511));
      end else begin
        int x = ac[j].x + $urandom_range(0, 50) - 25;
        int y = ac[j].y + $urandom_range(0, 50) - 25;
        px = 10'((x < 0) ? 0 : (x > 1023) ? 1023 : x);
        py = 9'((y < 0) ? 0 : (y > 511) ? 511 : y);
      end
      tick();
      checks++;
      if (seen_ready !== exp_ready)
        begin failures++; $display("FAIL rnd_ready n=%0d got=%b want=%b", n, seen_ready, exp_ready); end
      checks++;
      if (cvalid !== exp_v)
        begin failures++; $display("FAIL rnd_valid n=%0d got=%b want=%b", n, cvalid, exp_v); end
      if (exp_v) begin
        checks++;
        if (color !== exp_c)
          begin failures++; $display("FAIL rnd_color n=%0d got=%h want=%h", n, color, exp_c); end
      end
    end
    set_idle();
  endtask

  initial begin
    set_idle();
    set_upd(0, 0, 0, 0, '0, 0);
    bg = BG; px = '0; py = '0;
    for (int i = 0; i < N; i++) begin sh[i] = '{default: 0}; ac[i] = '{default: 0}; end
    frames = 0; prev_v = 0; prev_c = '0;
    @(posedge clk); #1;
    test_reset();
    test_background();
    test_single();
    test_overlap();
    test_edge();
    test_commit_stall();
    test_back_to_back();
    test_reset_midstream();
    test_blink();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
